bullcow_display: RTL and testbench

BULLCOW_DISPLAY -- requirements
Module: bullcow_display

---
 rtl/bullcow_display.sv | 178 +++++++++++++++++
 tb/tb_bullcow_display.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bullcow_display.sv
// Eight-digit multiplexed seven-segment driver for the bulls-and-cows game.
// Optional END_GAME blinking is compiled in with `define BULLCOW_DISP_BLINK_EN.
module bullcow_display #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] game_state,
   input  logic [2:0] bull_count,
   input  logic [2:0] cow_count,
   input  logic [7:0] J1_points,
   input  logic [7:0] J2_points,
   output logic [7:0] an,
   output logic [7:0] seg
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

   localparam logic [7:0] G_J     = 8'hE1;
   localparam logic [7:0] G_B     = 8'h83;
   localparam logic [7:0] G_C     = 8'hA7;
   localparam logic [7:0] G_DASH  = 8'hBF;
   localparam logic [7:0] G_BLANK = 8'hFF;

   if (REFRESH_DIV < 2 || BLINK_DIV < 2) begin : g_bad_param
      $error("bullcow_display: REFRESH_DIV and BLINK_DIV must be >= 2");
   end

   function automatic logic [7:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 8'hC0;
         4'h1: hex_glyph = 8'hF9;
         4'h2: hex_glyph = 8'hA4;
         4'h3: hex_glyph = 8'hB0;
         4'h4: hex_glyph = 8'h99;
         4'h5: hex_glyph = 8'h92;
         4'h6: hex_glyph = 8'h82;
         4'h7: hex_glyph = 8'hF8;
         4'h8: hex_glyph = 8'h80;
         4'h9: hex_glyph = 8'h90;
         4'hA: hex_glyph = 8'h88;
         4'hB: hex_glyph = 8'h83;
         4'hC: hex_glyph = 8'hC6;
         4'hD: hex_glyph = 8'hA1;
         4'hE: hex_glyph = 8'h86;
         default: hex_glyph = 8'h8E;
      endcase
   endfunction

   logic [RW-1:0] div_cnt;
   logic [2:0]    idx;
   logic [2:0]    prev_state;
   logic [2:0]    bull_l;
   logic [2:0]    cow_l;
   logic [7:0]    glyph;
   logic [7:0]    an_nxt;
   logic [7:0]    seg_nxt;
   logic [7:0]    player_glyph;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         idx     <= 3'd0;
      end else if (div_cnt == RW'(REFRESH_DIV - 1)) begin
         div_cnt <= '0;
         idx     <= idx + 3'd1;
      end else begin
         div_cnt <= div_cnt + RW'(1);
      end
   end

   // The result is captured only when the turn hands over between the guess states.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_state <= 3'b000;
         bull_l     <= 3'd0;
         cow_l      <= 3'd0;
      end else begin
         prev_state <= game_state;
         if (game_state == 3'b000 || game_state == 3'b001) begin
            bull_l <= 3'd0;
            cow_l  <= 3'd0;
         end else if ((prev_state == 3'b010 && game_state == 3'b011) ||
                      (prev_state == 3'b011 && game_state == 3'b010)) begin
            bull_l <= bull_count;
            cow_l  <= cow_count;
         end
      end
   end

   always_comb begin
      glyph        = G_DASH;
      player_glyph = game_state[0] ? hex_glyph(4'h2) : hex_glyph(4'h1);
      case (game_state)
         3'b000, 3'b001: begin
            case (idx)
               3'd7:    glyph = G_J;
               3'd6:    glyph = player_glyph;
               default: glyph = G_DASH;
            endcase
         end
         3'b010, 3'b011: begin
            case (idx)
               3'd7:    glyph = G_J;
               3'd6:    glyph = player_glyph;
               3'd4:    glyph = hex_glyph({1'b0, bull_l});
               3'd3:    glyph = G_B;
               3'd1:    glyph = hex_glyph({1'b0, cow_l});
               3'd0:    glyph = G_C;
               default: glyph = G_BLANK;
            endcase
         end
         3'b111: begin
            case (idx)
               3'd7:    glyph = G_J;
               3'd6:    glyph = hex_glyph(4'h1);
               3'd5:    glyph = hex_glyph(J1_points[7:4]);
               3'd4:    glyph = hex_glyph(J1_points[3:0]);
               3'd3:    glyph = G_J;
               3'd2:    glyph = hex_glyph(4'h2);
               3'd1:    glyph = hex_glyph(J2_points[7:4]);
               default: glyph = hex_glyph(J2_points[3:0]);
            endcase
         end
         default: glyph = G_DASH;
      endcase
   end

`ifdef BULLCOW_DISP_BLINK_EN
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   logic [BW-1:0] blink_cnt;
   logic          hidden;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         blink_cnt <= '0;
         hidden    <= 1'b0;
      end else if (game_state == 3'b111) begin
         if (blink_cnt == BW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            hidden    <= ~hidden;
         end else begin
            blink_cnt <= blink_cnt + BW'(1);
         end
      end else begin
         blink_cnt <= '0;
         hidden    <= 1'b0;
      end
   end

   // Scanning keeps running while hidden; only the drive is masked.
   always_comb begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = glyph;
      if (hidden) begin
         an_nxt  = 8'hFF;
         seg_nxt = 8'hFF;
      end
   end
`else
   always_comb begin
      an_nxt  = ~(8'd1 << idx);
      seg_nxt = glyph;
   end
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         an  <= 8'hFF;
         seg <= 8'hFF;
      end else begin
         an  <= an_nxt;
         seg <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_bullcow_display.sv
// Directed self-checking bench for bullcow_display (REFRESH_DIV=4, BLINK_DIV=16);
// expected digits are queued and matched as the scan reaches each digit.
module tb_bullcow_display;

   logic       clock;
   logic       reset;
   logic [2:0] game_state;
   logic [2:0] bull_count;
   logic [2:0] cow_count;
   logic [7:0] J1_points;
   logic [7:0] J2_points;
   logic [7:0] an;
   logic [7:0] seg;

   int checks = 0;
   int errors = 0;

   logic [15:0] exp_q[$];
   string       tag_q[$];

   bullcow_display #(.REFRESH_DIV(4), .BLINK_DIV(16)) dut (
      .clock(clock), .reset(reset), .game_state(game_state),
      .bull_count(bull_count), .cow_count(cow_count),
      .J1_points(J1_points), .J2_points(J2_points), .an(an), .seg(seg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_digit(input int d, input logic [7:0] s, input string tag);
      logic [7:0] a;
      a = ~(8'd1 << d);
      exp_q.push_back({a, s});
      tag_q.push_back(tag);
   endtask

   // Waits (bounded) for each queued digit to come up in the scan, then compares.
   task automatic drain();
      logic [15:0] e;
      string       t;
      int          n;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n = 0;
         while (an !== e[15:8] && n < 64) begin
            @(negedge clock);
            n++;
         end
         checks++;
         assert (an === e[15:8] && seg === e[7:0]) else begin
            errors++;
            $error("FAIL %s: observed an=%h seg=%h expected an=%h seg=%h",
                   t, an, seg, e[15:8], e[7:0]);
         end
      end
   endtask

   initial begin
      int n;
      int blanks;
      reset      = 1'b1;
      game_state = 3'b000;
      bull_count = 3'd0;
      cow_count  = 3'd0;
      J1_points  = 8'h00;
      J2_points  = 8'h00;
      #3;
      check8("reset_an", an, 8'hFF);
      check8("reset_seg", seg, 8'hFF);
      cyc(2);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check8("first_an", an, 8'hFE);
         check8("first_seg", seg, 8'hBF);
      end
      @(negedge clock);
      check8("second_an", an, 8'hFD);
      expect_digit(6, 8'hF9, "s000_d6");
      expect_digit(7, 8'hE1, "s000_d7");
      drain();

      game_state = 3'b001;
      cyc(2);
      expect_digit(0, 8'hBF, "s001_d0");
      expect_digit(6, 8'hA4, "s001_d6");
      expect_digit(7, 8'hE1, "s001_d7");
      drain();

      bull_count = 3'd5;
      cow_count  = 3'd6;
      game_state = 3'b010;
      cyc(2);
      expect_digit(0, 8'hA7, "s010_clr_d0");
      expect_digit(1, 8'hC0, "s010_clr_d1");
      expect_digit(3, 8'h83, "s010_clr_d3");
      expect_digit(4, 8'hC0, "s010_clr_d4");
      expect_digit(5, 8'hFF, "s010_clr_d5");
      expect_digit(6, 8'hF9, "s010_clr_d6");
      drain();

      bull_count = 3'd2;
      cow_count  = 3'd1;
      game_state = 3'b011;
      cyc(2);
      expect_digit(0, 8'hA7, "cap21_d0");
      expect_digit(1, 8'hF9, "cap21_d1");
      expect_digit(3, 8'h83, "cap21_d3");
      expect_digit(4, 8'hA4, "cap21_d4");
      expect_digit(6, 8'hA4, "cap21_d6");
      drain();
      bull_count = 3'd7;
      cow_count  = 3'd4;
      cyc(2);
      expect_digit(1, 8'hF9, "hold_d1");
      expect_digit(4, 8'hA4, "hold_d4");
      drain();

      bull_count = 3'd3;
      cow_count  = 3'd0;
      game_state = 3'b010;
      cyc(2);
      expect_digit(4, 8'hB0, "cap30_d4");
      expect_digit(6, 8'hF9, "cap30_d6");
      drain();
      bull_count = 3'd7;
      cow_count  = 3'd7;
      game_state = 3'b011;
      cyc(2);
      expect_digit(4, 8'hF8, "cap77_d4");
      expect_digit(1, 8'hF8, "cap77_d1");
      drain();
      bull_count = 3'd3;
      cow_count  = 3'd0;
      game_state = 3'b010;
      cyc(2);
      game_state = 3'b011;
      cyc(3);
      game_state = 3'b000;
      cyc(3);
      game_state = 3'b001;
      cyc(3);
      game_state = 3'b010;
      cyc(2);
      expect_digit(4, 8'hC0, "reentry_d4");
      expect_digit(1, 8'hC0, "reentry_d1");
      drain();

      J1_points  = 8'h1A;
      J2_points  = 8'h03;
      game_state = 3'b111;
`ifdef BULLCOW_DISP_BLINK_EN
      n = 0;
      while (an !== 8'hFF && n < 40) begin
         @(negedge clock);
         n++;
      end
      blanks = 0;
      while (an === 8'hFF && blanks < 40) begin
         @(negedge clock);
         blanks++;
      end
      checks++;
      assert (blanks == 16) else begin
         errors++;
         $error("FAIL blink_hidden_len: observed=%0d expected=%0d", blanks, 16);
      end
      check8("blink_resume_an", (an === 8'hFF) ? 8'h00 : 8'h01, 8'h01);
`else
      cyc(2);
      expect_digit(0, 8'hB0, "end_d0");
      expect_digit(1, 8'hC0, "end_d1");
      expect_digit(2, 8'hA4, "end_d2");
      expect_digit(3, 8'hE1, "end_d3");
      expect_digit(4, 8'h88, "end_d4");
      expect_digit(5, 8'hF9, "end_d5");
      expect_digit(6, 8'hF9, "end_d6");
      expect_digit(7, 8'hE1, "end_d7");
      drain();
      blanks = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge clock);
         if (an === 8'hFF) blanks++;
      end
      checks++;
      assert (blanks == 0) else begin
         errors++;
         $error("FAIL no_blink: observed=%0d blank cycles expected=%0d", blanks, 0);
      end
`endif

      game_state = 3'b101;
      cyc(2);
      for (int d = 0; d < 8; d++) expect_digit(d, 8'hBF, "s101_dash");
      drain();

      n = 0;
      while (an !== 8'hDF && n < 64) begin
         @(negedge clock);
         n++;
      end
      check8("midscan_at_d5", an, 8'hDF);
      reset = 1'b1;
      #1;
      check8("midscan_reset_an", an, 8'hFF);
      check8("midscan_reset_seg", seg, 8'hFF);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check8("restart_an", an, 8'hFE);
      check8("restart_seg", seg, 8'hBF);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
